odev1_bist: RTL and testbench

- Synthesizable self-test controller for the 5-input odev1 logic function: the hardware counterpart of the bench-side checker.
- Walks all 32 input combinations on A..E, samples the DUT output F after a settle interval, and compares it against a golden truth table.
- Reports pass/fail counts, first failing index and summary flags.
- Sits beside odev1_fonk on the board top level; results go to LEDs or the seven-segment display.

---
 rtl/odev1_bist.sv | 117 +++++++++++
 tb/tb_odev1_bist.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/odev1_bist.sv
// Self-test controller for the 5-input odev1 function: sweeps all 32 vectors and scores F.
// Optional ODEV1_BIST_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module odev1_bist #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [31:0] GOLDEN        = 32'hEFFF8FFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    input  logic       F,
    output logic       busy,
    output logic       done,
    output logic [5:0] pass_cnt,
    output logic [5:0] fail_cnt,
    output logic       all_pass,
    output logic       all_fail,
    output logic [4:0] first_fail_idx,
    output logic       first_fail_valid,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [4:0] idx;
    logic [3:0] wait_cnt;
    logic       match;
    logic       launch;

    assign match  = (F == GOLDEN[idx]);
    assign launch = start && ((state == S_IDLE) || (state == S_DONE));

    // The stimulus is the vector index itself, so A..E are flop outputs.
    assign {A, B, C, D, E} = idx;

    assign busy      = (state == S_WAIT) || (state == S_CHECK);
    assign done      = (state == S_DONE);
    assign all_pass  = done && (pass_cnt == 6'd32);
    assign all_fail  = done && (fail_cnt == 6'd32);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_WAIT;
            S_DONE:  if (start) state_next = S_WAIT;
            S_WAIT:  if (wait_cnt == SETTLE_LAST) state_next = S_CHECK;
            S_CHECK: begin
                if (idx == 5'd31) begin
                    state_next = S_DONE;
                end
`ifdef ODEV1_BIST_STOP_ON_FAIL_EN
                else if (!match) begin
                    state_next = S_DONE;
                end
`endif
                else begin
                    state_next = S_WAIT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            idx              <= 5'd0;
            wait_cnt         <= 4'd0;
            pass_cnt         <= 6'd0;
            fail_cnt         <= 6'd0;
            first_fail_idx   <= 5'd0;
            first_fail_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (launch) begin
                idx              <= 5'd0;
                wait_cnt         <= 4'd0;
                pass_cnt         <= 6'd0;
                fail_cnt         <= 6'd0;
                first_fail_idx   <= 5'd0;
                first_fail_valid <= 1'b0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else if (state == S_CHECK) begin
                if (match) begin
                    pass_cnt <= pass_cnt + 6'd1;
                end else begin
                    fail_cnt <= fail_cnt + 6'd1;
                    if (!first_fail_valid) begin
                        first_fail_idx   <= idx;
                        first_fail_valid <= 1'b1;
                    end
                end
                // idx is left in place on the way to DONE so A..E keep the last vector.
                if (state_next == S_WAIT) begin
                    idx      <= idx + 5'd1;
                    wait_cnt <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_odev1_bist.sv
// Bench for odev1_bist: drives F from a 32-entry response table and scores the
// controller against a vector-by-vector reference model.
module tb_odev1_bist;

    localparam int SETTLE     = 1;
    localparam int VEC_CYCLES = SETTLE + 1;
    localparam int TIMEOUT    = 32 * VEC_CYCLES + 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        A, B, C, D, E;
    logic        F;
    logic        busy, done;
    logic [5:0]  pass_cnt, fail_cnt;
    logic        all_pass, all_fail;
    logic [4:0]  first_fail_idx;
    logic        first_fail_valid;
    logic [1:0]  fsm_state;
    logic [4:0]  abcde;
    logic [31:0] f_table = 32'h0;

    int checks = 0;
    int passes = 0;

    // reference model results
    int         m_pass, m_fail, m_ffi, m_ran;
    bit         m_ffv;
    logic [4:0] m_abcde;

    odev1_bist #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
        .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .all_pass(all_pass), .all_fail(all_fail),
        .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    assign abcde = {A, B, C, D, E};
    assign F     = f_table[abcde];

    // odev1 is 1 everywhere except these four input combinations
    function automatic logic golden_f(input int i);
        return !(i == 12 || i == 13 || i == 14 || i == 28);
    endfunction

    function automatic logic [31:0] golden_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = golden_f(i);
        return v;
    endfunction

    task automatic model_run(input logic [31:0] tbl);
        bit stopped;
        stopped = 0;
        m_pass = 0; m_fail = 0; m_ffi = 0; m_ran = 0; m_ffv = 0; m_abcde = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (!stopped) begin
                m_ran++;
                m_abcde = 5'(i);
                if (tbl[i] == golden_f(i)) begin
                    m_pass++;
                end else begin
                    m_fail++;
                    if (!m_ffv) begin
                        m_ffv = 1;
                        m_ffi = i;
                    end
`ifdef ODEV1_BIST_STOP_ON_FAIL_EN
                    stopped = 1;
`endif
                end
            end
        end
    endtask

    task automatic run_vectors(output int edges, output logic busy0, output logic done0,
                               output logic [5:0] pc0, output logic [5:0] fc0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy0 = busy; done0 = done; pc0 = pass_cnt; fc0 = fail_cnt;
        edges = 0;
        while (done !== 1'b1 && edges < TIMEOUT) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pass_cnt, fail_cnt, all_pass, all_fail, first_fail_idx, first_fail_valid} !== 23'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b pc=%0d fc=%0d ap=%b af=%b ffi=%0d ffv=%b, expected all 0",
                     busy, done, pass_cnt, fail_cnt, all_pass, all_fail, first_fail_idx, first_fail_valid);
        else passes++;
        checks++;
        if (abcde !== 5'd0 || fsm_state !== 2'd0)
            $display("FAIL reset_state: got abcde=%b state=%0d, expected 00000/0", abcde, fsm_state);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_patterns();
        int edges, idle;
        logic busy0, done0;
        logic [5:0] pc0, fc0;
        for (int p = 0; p < 9; p++) begin
            case (p)
                0: f_table = golden_vec();
                1: f_table = 32'hFFFF_FFFF;
                2: f_table = ~golden_vec();
                3: f_table = golden_vec() ^ 32'h8000_0000;
                default: f_table = golden_vec() ^ ($urandom() & $urandom() & $urandom());
            endcase
            model_run(f_table);
            run_vectors(edges, busy0, done0, pc0, fc0);
            checks++;
            if (busy0 !== 1'b1 || done0 !== 1'b0 || pc0 !== 6'd0 || fc0 !== 6'd0)
                $display("FAIL pat%0d_launch: got busy=%b done=%b pc=%0d fc=%0d, expected 1/0/0/0",
                         p, busy0, done0, pc0, fc0);
            else passes++;
            checks++;
            if (edges != m_ran * VEC_CYCLES)
                $display("FAIL pat%0d_done_edge: got %0d expected %0d", p, edges, m_ran * VEC_CYCLES);
            else passes++;
            idle = $urandom_range(0, 4);
            repeat (idle) @(posedge clk);
            #1;
            checks++;
            if (pass_cnt !== 6'(m_pass) || fail_cnt !== 6'(m_fail))
                $display("FAIL pat%0d_counts: got %0d/%0d expected %0d/%0d", p, pass_cnt, fail_cnt, m_pass, m_fail);
            else passes++;
            checks++;
            if (first_fail_valid !== m_ffv || first_fail_idx !== 5'(m_ffi))
                $display("FAIL pat%0d_first_fail: got valid=%b idx=%0d expected valid=%b idx=%0d",
                         p, first_fail_valid, first_fail_idx, m_ffv, m_ffi);
            else passes++;
            checks++;
            if (all_pass !== (m_pass == 32) || all_fail !== (m_fail == 32))
                $display("FAIL pat%0d_flags: got all_pass=%b all_fail=%b expected %b/%b",
                         p, all_pass, all_fail, m_pass == 32, m_fail == 32);
            else passes++;
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || abcde !== m_abcde)
                $display("FAIL pat%0d_final: got done=%b busy=%b abcde=%b expected 1/0/%b",
                         p, done, busy, abcde, m_abcde);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_run();
        int edges;
        logic busy0, done0;
        logic [5:0] pc0, fc0;
        f_table = golden_vec();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10 * VEC_CYCLES) @(posedge clk);
        #1;
        checks++;
        if (abcde !== 5'd10 || busy !== 1'b1 || pass_cnt !== 6'd10)
            $display("FAIL midrun_progress: got abcde=%0d busy=%b pc=%0d expected 10/1/10", abcde, busy, pass_cnt);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pass_cnt, fail_cnt, all_pass, all_fail, first_fail_idx, first_fail_valid} !== 23'd0
            || abcde !== 5'd0 || fsm_state !== 2'd0)
            $display("FAIL midrun_reset: got busy=%b done=%b pc=%0d fc=%0d abcde=%b state=%0d expected all 0",
                     busy, done, pass_cnt, fail_cnt, abcde, fsm_state);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        run_vectors(edges, busy0, done0, pc0, fc0);
        checks++;
        if (edges != 32 * VEC_CYCLES || pass_cnt !== 6'd32 || fail_cnt !== 6'd0 || all_pass !== 1'b1)
            $display("FAIL midrun_rerun: got edges=%0d pc=%0d fc=%0d ap=%b expected %0d/32/0/1",
                     edges, pass_cnt, fail_cnt, all_pass, 32 * VEC_CYCLES);
        else passes++;
    endtask

    task automatic test_start_while_busy();
        int edges;
        f_table = golden_vec();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < TIMEOUT) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 5 * VEC_CYCLES) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (edges != 32 * VEC_CYCLES)
            $display("FAIL busy_start_edge: got %0d expected %0d", edges, 32 * VEC_CYCLES);
        else passes++;
        checks++;
        if (pass_cnt !== 6'd32 || fail_cnt !== 6'd0)
            $display("FAIL busy_start_counts: got %0d/%0d expected 32/0", pass_cnt, fail_cnt);
        else passes++;
    endtask

    task automatic test_restart_from_done();
        int edges;
        logic busy0, done0;
        logic [5:0] pc0, fc0;
        f_table = ~golden_vec();
        model_run(f_table);
        run_vectors(edges, busy0, done0, pc0, fc0);
        checks++;
        if (fail_cnt !== 6'(m_fail) || done !== 1'b1)
            $display("FAIL restart_first: got fc=%0d done=%b expected %0d/1", fail_cnt, done, m_fail);
        else passes++;
        f_table = golden_vec();
        run_vectors(edges, busy0, done0, pc0, fc0);
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || fc0 !== 6'd0)
            $display("FAIL restart_clear: got done=%b busy=%b fc=%0d expected 0/1/0", done0, busy0, fc0);
        else passes++;
        checks++;
        if (edges != 32 * VEC_CYCLES || pass_cnt !== 6'd32 || first_fail_valid !== 1'b0)
            $display("FAIL restart_result: got edges=%0d pc=%0d ffv=%b expected %0d/32/0",
                     edges, pass_cnt, first_fail_valid, 32 * VEC_CYCLES);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_reset_mid_run();
        test_start_while_busy();
        test_restart_from_done();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
